fft_r2_iter: RTL and testbench
==============================

Name: fft_r2_iter

Overview:
Parametrised iterative radix-2 decimation-in-time FFT core, the run-time-streaming successor to the fixed 8-point combinational FFT. It accepts one complex sample per cycle over a valid/ready stream and stores each frame of N samples in bit-reversed order in an internal register buffer. It computes log2(N) stages in place using one shared butterfly, then streams the N bins out in natural order. It sits between the sample front-end and the spectral post-processing blocks of the DSP chain.

Parameters:
DATA_WIDTH, 16, width of each real and imaginary sample, two's complement.
N, 8, FFT points; power of two, 4..256; elaboration error otherwise.
FRAC_WIDTH, 8, fractional bits of the twiddle factors; range 1..DATA_WIDTH-2.
SCALE, 1, 1 = arithmetic shift right by 1 after every stage (total 1/N); 0 = no scaling.

Ports:
clk  in  1  clock, rising edge.
arst_n  in  1  asynchronous active-low reset.
s_valid  in  1  input sample valid.
s_ready  out  1  core accepts an input sample.
s_real  in  DATA_WIDTH  input sample, real part.
s_imag  in  DATA_WIDTH  input sample, imaginary part.
m_valid  out  1  output bin valid.
m_ready  in  1  downstream accepts an output bin.
m_real  out  DATA_WIDTH  output bin, real part.
m_imag  out  DATA_WIDTH  output bin, imaginary part.
m_index  out  $clog2(N)  bin number of the current output.
m_last  out  1  high with bin N-1.
busy  out  1  high in COMPUTE.
overflow  out  1  sticky saturation flag for the current frame.

Behaviour:
- Clock and reset: one clock, clk. Reset arst_n is asynchronous, active-low. In reset the FSM enters LOAD and all counters clear. Outputs in reset: s_ready=1, m_valid=0, m_real=0, m_imag=0, m_index=0, m_last=0, busy=0, overflow=0. Buffer contents are don't-care.
- FSM states:
  - LOAD: s_ready=1. A handshake (s_valid && s_ready) writes the sample to buffer[bitrev(cnt)] and increments cnt. The first handshake of a frame clears overflow. The handshake at cnt=N-1 moves to COMPUTE.
  - COMPUTE: s_ready=0, busy=1. One butterfly per cycle, N/2 butterflies per stage, log2(N) stages, so exactly (N/2)*log2(N) cycles. After the last butterfly, go to UNLOAD.
  - UNLOAD: m_valid=1, with m_real/m_imag = buffer[idx] and m_index=idx. A handshake increments idx. The handshake at idx=N-1 (m_last=1) moves to LOAD. With m_valid high and m_ready low, all m_* outputs hold stable.
- Frames do not overlap. Input is not accepted during COMPUTE or UNLOAD.
- Butterfly addressing for stage s=0..log2(N)-1 and butterfly b=0..N/2-1:
  - half = 2^s, pos = b mod half.
  - top = (b/half)*2*half + pos, bot = top + half.
  - Twiddle index k = pos*N/(2*half).
- Twiddles: W[k] = cos(2*pi*k/N) - j*sin(2*pi*k/N), k=0..N/2-1. Each value is rounded to nearest at scale 2^FRAC_WIDTH and held in a constant table built at elaboration. W[0] = (2^FRAC_WIDTH, 0).
- Butterfly arithmetic, computed at full precision (2*DATA_WIDTH+2 bits):
  - P = B*W, then arithmetic shift right by FRAC_WIDTH (truncation).
  - Y0 = A + P, Y1 = A - P.
  - If SCALE=1, Y0 and Y1 are shifted right by 1 (arithmetic).
  - The result is saturated to DATA_WIDTH. Any saturation sets overflow, which holds until the next frame's first input.
- Latency: N input handshakes, then (N/2)*log2(N) compute cycles. The first m_valid rises on the cycle after the last butterfly write.
- Reset asserted mid-frame (any state) aborts the frame. No partial output is emitted; the core returns to LOAD.
- s_valid while s_ready=0 is ignored and no sample is lost: the source holds it. m_ready while m_valid=0 has no effect.

Test Plan:
1. N=8, SCALE=0, impulse: x[0]=(256,0), all others 0 -> all 8 bins = (256,0), m_index 0..7, m_last only on bin 7, overflow=0.
2. N=8, SCALE=1, x_real=256*(1..8), x_imag=256 for all -> bin0=(1152,256). busy high exactly 12 cycles. m_valid rises on the first cycle after busy falls.
3. N=8, SCALE=0, alternating +256/-256 real -> bin4=(2048,0), all other bins (0,0). Repeat with N=16 -> bin8=(4096,0).
4. N=8, SCALE=0, all inputs (32767,0) -> bin0=(32767,0) saturated, overflow=1. Next frame's first input handshake clears overflow to 0.
5. Backpressure: m_ready toggled randomly during UNLOAD, and s_valid asserted during COMPUTE/UNLOAD -> m_* stable while stalled, s_ready=0 outside LOAD, no samples dropped or duplicated, results identical to the unstalled run.
6. arst_n pulsed low mid-COMPUTE -> all outputs at reset values immediately; the next full frame (impulse) produces correct bins.

Source files
------------

// File: rtl/fft_r2_iter.sv
// Iterative radix-2 DIT FFT: loads a frame in bit-reversed order, runs log2(N) in-place
// stages through one shared butterfly, then streams the bins out in natural order.
module fft_r2_iter #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int SCALE      = 1
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_real,
  input  logic [DATA_WIDTH-1:0]   s_imag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_real,
  output logic [DATA_WIDTH-1:0]   m_imag,
  output logic [$clog2(N)-1:0]    m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic                    overflow,
  output logic [1:0]              state_dbg
);

  localparam int AW = $clog2(N);
  localparam int BW = AW - 1;
  localparam int SW = $clog2(AW);
  localparam int FW = 2 * DATA_WIDTH + 2;
  localparam logic signed [FW-1:0] SAT_MAX = (FW'(1) << (DATA_WIDTH - 1)) - FW'(1);
  localparam logic signed [FW-1:0] SAT_MIN = ~SAT_MAX;

  if (N < 4 || N > 256 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("fft_r2_iter: N must be a power of two in 4..256");
  end
  if (FRAC_WIDTH < 1 || FRAC_WIDTH > DATA_WIDTH - 2) begin : g_bad_frac
    $error("fft_r2_iter: FRAC_WIDTH must be in 1..DATA_WIDTH-2");
  end

  // Stream handshakes: a transfer happens on a rising clk edge where valid && ready;
  // s_ready depends only on the FSM state, and m_* hold stable while m_valid && !m_ready.

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_re [N];
  logic [DATA_WIDTH-1:0] mem_im [N];
  logic [DATA_WIDTH-1:0] tw_re [N/2];
  logic [DATA_WIDTH-1:0] tw_im [N/2];

  logic [AW-1:0] cnt;
  logic [SW-1:0] stage;
  logic [BW-1:0] bfly;
  logic          overflow_q;

  logic          load_fire;
  logic          unload_fire;
  logic          last_bfly;
  logic          sat_any;

  // Twiddle ROM, W[k] = cos(2*pi*k/N) - j*sin(2*pi*k/N), rounded at 2^FRAC_WIDTH.
  genvar gk;
  for (gk = 0; gk < N/2; gk++) begin : g_tw
    localparam real ANG = 6.283185307179586 * real'(gk) / real'(N);
    localparam real SCL = real'(1 << FRAC_WIDTH);
    localparam int  TR  = int'($cos(ANG) * SCL);
    localparam int  TI  = -int'($sin(ANG) * SCL);
    assign tw_re[gk] = DATA_WIDTH'(TR);
    assign tw_im[gk] = DATA_WIDTH'(TI);
  end

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  function automatic logic signed [FW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(FW-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [FW-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic over(input logic signed [FW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  // Butterfly addressing: top/bot are the pair for butterfly bfly of stage, tw_idx its twiddle.
  logic [AW-1:0] b_ext, half, pos, top, bot;
  logic [BW-1:0] tw_idx;

  always_comb begin
    b_ext  = {1'b0, bfly};
    half   = AW'(1) << stage;
    pos    = b_ext & (half - AW'(1));
    top    = ((b_ext & ~(half - AW'(1))) << 1) | pos;
    bot    = top | half;
    tw_idx = BW'(pos << (AW - 1 - int'(stage)));
  end

  logic signed [FW-1:0] ar, ai, br, bi, wr, wi, pr, pi;
  logic signed [FW-1:0] y0r, y0i, y1r, y1i;

  always_comb begin
    ar  = sext(mem_re[top]);
    ai  = sext(mem_im[top]);
    br  = sext(mem_re[bot]);
    bi  = sext(mem_im[bot]);
    wr  = sext(tw_re[tw_idx]);
    wi  = sext(tw_im[tw_idx]);
    pr  = (br * wr - bi * wi) >>> FRAC_WIDTH;
    pi  = (br * wi + bi * wr) >>> FRAC_WIDTH;
    y0r = ar + pr;
    y0i = ai + pi;
    y1r = ar - pr;
    y1i = ai - pi;
    if (SCALE != 0) begin
      y0r = y0r >>> 1;
      y0i = y0i >>> 1;
      y1r = y1r >>> 1;
      y1i = y1i >>> 1;
    end
    sat_any = over(y0r) | over(y0i) | over(y1r) | over(y1i);
  end

  assign load_fire   = (state_q == ST_LOAD) && s_valid;
  assign unload_fire = (state_q == ST_UNLOAD) && m_ready;
  assign last_bfly   = (stage == SW'(AW - 1)) && (bfly == BW'(N/2 - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_LOAD;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:    if (load_fire && cnt == AW'(N - 1)) state_d = ST_COMPUTE;
      ST_COMPUTE: if (last_bfly) state_d = ST_UNLOAD;
      ST_UNLOAD:  if (unload_fire && cnt == AW'(N - 1)) state_d = ST_LOAD;
      default:    state_d = ST_LOAD;
    endcase
  end

  // FSM: outputs; m_* are forced to zero outside UNLOAD so reset values are defined.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    m_last  = 1'b0;
    m_index = '0;
    m_real  = '0;
    m_imag  = '0;
    case (state_q)
      ST_LOAD:    s_ready = 1'b1;
      ST_COMPUTE: busy = 1'b1;
      ST_UNLOAD: begin
        m_valid = 1'b1;
        m_index = cnt;
        m_real  = mem_re[cnt];
        m_imag  = mem_im[cnt];
        m_last  = (cnt == AW'(N - 1));
      end
      default: ;
    endcase
  end

  assign overflow  = overflow_q;
  assign state_dbg = state_q;

  // cnt serves as load index and unload index; it wraps to 0 at both frame boundaries.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt        <= '0;
      stage      <= '0;
      bfly       <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_fire) begin
            cnt <= cnt + AW'(1);
            if (cnt == '0) overflow_q <= 1'b0;
          end
        end
        ST_COMPUTE: begin
          if (sat_any) overflow_q <= 1'b1;
          if (bfly == BW'(N/2 - 1)) begin
            bfly  <= '0;
            stage <= (stage == SW'(AW - 1)) ? '0 : stage + SW'(1);
          end else begin
            bfly <= bfly + BW'(1);
          end
        end
        ST_UNLOAD: begin
          if (unload_fire) cnt <= cnt + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sample buffer; contents are meaningless after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_re[bitrev(cnt)] <= s_real;
      mem_im[bitrev(cnt)] <= s_imag;
    end else if (state_q == ST_COMPUTE) begin
      mem_re[top] <= sat(y0r);
      mem_im[top] <= sat(y0i);
      mem_re[bot] <= sat(y1r);
      mem_im[bot] <= sat(y1i);
    end
  end

endmodule

// File: tb/tb_fft_r2_iter.sv
// Bench for fft_r2_iter: three instances (N=8/SCALE=0, N=8/SCALE=1, N=16/SCALE=0) sharing one
// stimulus port, a spec-level FFT model feeding an expected queue, and directed corner sequences.
module tb_fft_r2_iter;
  localparam int DW = 16;
  localparam int W  = 1 + 8 + DW + DW;

  localparam int P_IMP  = 0;
  localparam int P_RAMP = 1;
  localparam int P_ALT  = 2;
  localparam int P_SAT  = 3;
  localparam int P_RND  = 4;
  localparam int P_FULL = 5;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic          s_valid, m_ready;
  logic [DW-1:0] s_real, s_imag;
  int            sel;

  logic          a_s_ready, a_m_valid, a_m_last, a_busy, a_ovf;
  logic [DW-1:0] a_m_real, a_m_imag;
  logic [2:0]    a_m_index;
  logic [1:0]    a_state;
  logic          b_s_ready, b_m_valid, b_m_last, b_busy, b_ovf;
  logic [DW-1:0] b_m_real, b_m_imag;
  logic [2:0]    b_m_index;
  logic [1:0]    b_state;
  logic          c_s_ready, c_m_valid, c_m_last, c_busy, c_ovf;
  logic [DW-1:0] c_m_real, c_m_imag;
  logic [3:0]    c_m_index;
  logic [1:0]    c_state;

  fft_r2_iter #(.DATA_WIDTH(DW), .N(8), .FRAC_WIDTH(8), .SCALE(0)) dut_a (
    .clk(clk), .arst_n(arst_n), .s_valid(s_valid && sel == 0), .s_ready(a_s_ready),
    .s_real(s_real), .s_imag(s_imag), .m_valid(a_m_valid), .m_ready(m_ready && sel == 0),
    .m_real(a_m_real), .m_imag(a_m_imag), .m_index(a_m_index), .m_last(a_m_last),
    .busy(a_busy), .overflow(a_ovf), .state_dbg(a_state));

  fft_r2_iter #(.DATA_WIDTH(DW), .N(8), .FRAC_WIDTH(8), .SCALE(1)) dut_b (
    .clk(clk), .arst_n(arst_n), .s_valid(s_valid && sel == 1), .s_ready(b_s_ready),
    .s_real(s_real), .s_imag(s_imag), .m_valid(b_m_valid), .m_ready(m_ready && sel == 1),
    .m_real(b_m_real), .m_imag(b_m_imag), .m_index(b_m_index), .m_last(b_m_last),
    .busy(b_busy), .overflow(b_ovf), .state_dbg(b_state));

  fft_r2_iter #(.DATA_WIDTH(DW), .N(16), .FRAC_WIDTH(8), .SCALE(0)) dut_c (
    .clk(clk), .arst_n(arst_n), .s_valid(s_valid && sel == 2), .s_ready(c_s_ready),
    .s_real(s_real), .s_imag(s_imag), .m_valid(c_m_valid), .m_ready(m_ready && sel == 2),
    .m_real(c_m_real), .m_imag(c_m_imag), .m_index(c_m_index), .m_last(c_m_last),
    .busy(c_busy), .overflow(c_ovf), .state_dbg(c_state));

  logic          s_ready_m, m_valid_m, m_last_m, busy_m, overflow_m;
  logic [DW-1:0] m_real_m, m_imag_m;
  logic [7:0]    m_index_m;
  logic [1:0]    state_m;

  always_comb begin
    s_ready_m = 1'b0; m_valid_m = 1'b0; m_last_m = 1'b0; busy_m = 1'b0; overflow_m = 1'b0;
    m_real_m = '0; m_imag_m = '0; m_index_m = '0; state_m = '0;
    case (sel)
      0: begin
        s_ready_m = a_s_ready; m_valid_m = a_m_valid; m_last_m = a_m_last; busy_m = a_busy;
        overflow_m = a_ovf; m_real_m = a_m_real; m_imag_m = a_m_imag;
        m_index_m = 8'(a_m_index); state_m = a_state;
      end
      1: begin
        s_ready_m = b_s_ready; m_valid_m = b_m_valid; m_last_m = b_m_last; busy_m = b_busy;
        overflow_m = b_ovf; m_real_m = b_m_real; m_imag_m = b_m_imag;
        m_index_m = 8'(b_m_index); state_m = b_state;
      end
      2: begin
        s_ready_m = c_s_ready; m_valid_m = c_m_valid; m_last_m = c_m_last; busy_m = c_busy;
        overflow_m = c_ovf; m_real_m = c_m_real; m_imag_m = c_m_imag;
        m_index_m = 8'(c_m_index); state_m = c_state;
      end
      default: ;
    endcase
  end

  int checks;
  int errors;
  int in_re [256];
  int in_im [256];
  int got_re [256];
  int got_im [256];
  int model_ovf;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int sel;
    int pat;
    int bin;
    int exp_re;
    int exp_im;
    int exp_ovf;
    int bp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", name, got, exp, $time, sel);
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got last=%0d idx=%0d re=%0d im=%0d expected last=%0d idx=%0d re=%0d im=%0d",
               name, got[W-1], got[W-2 -: 8], $signed(got[2*DW-1 -: DW]), $signed(got[DW-1:0]),
               exp[W-1], exp[W-2 -: 8], $signed(exp[2*DW-1 -: DW]), $signed(exp[DW-1:0]));
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int bitrev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (((v >> i) & 1) != 0) r |= 1 << (bits - 1 - i);
    return r;
  endfunction

  function automatic longint twr(input int k, input int n);
    return longint'(int'($cos(6.283185307179586 * real'(k) / real'(n)) * 256.0));
  endfunction

  function automatic longint twi(input int k, input int n);
    return longint'(-int'($sin(6.283185307179586 * real'(k) / real'(n)) * 256.0));
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) begin model_ovf = 1; return 32767; end
    if (v < -32768) begin model_ovf = 1; return -32768; end
    return v;
  endfunction

  task automatic model(input int n, input int sc);
    longint xr [256];
    longint xi [256];
    int lg = $clog2(n);
    model_ovf = 0;
    for (int i = 0; i < n; i++) begin
      xr[bitrev(i, lg)] = in_re[i];
      xi[bitrev(i, lg)] = in_im[i];
    end
    for (int half = 1; half < n; half = half * 2) begin
      for (int g = 0; g < n; g += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          int k = j * n / (2 * half);
          longint wr = twr(k, n);
          longint wi = twi(k, n);
          longint br = xr[g + j + half];
          longint bi = xi[g + j + half];
          longint pr = (br * wr - bi * wi) >>> 8;
          longint pi = (br * wi + bi * wr) >>> 8;
          longint y0r = xr[g + j] + pr;
          longint y0i = xi[g + j] + pi;
          longint y1r = xr[g + j] - pr;
          longint y1i = xi[g + j] - pi;
          if (sc != 0) begin
            y0r = y0r >>> 1; y0i = y0i >>> 1; y1r = y1r >>> 1; y1i = y1i >>> 1;
          end
          xr[g + j] = sat16(y0r);
          xi[g + j] = sat16(y0i);
          xr[g + j + half] = sat16(y1r);
          xi[g + j + half] = sat16(y1i);
        end
      end
    end
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'(i == n - 1), 8'(i), DW'(xr[i]), DW'(xi[i])});
  endtask

  task automatic fill(input int pat, input int n);
    for (int i = 0; i < n; i++) begin
      case (pat)
        P_IMP:   begin in_re[i] = (i == 0) ? 256 : 0; in_im[i] = 0; end
        P_RAMP:  begin in_re[i] = 256 * (i + 1); in_im[i] = 256; end
        P_ALT:   begin in_re[i] = (i % 2 == 0) ? 256 : -256; in_im[i] = 0; end
        P_SAT:   begin in_re[i] = 32767; in_im[i] = 0; end
        P_RND:   begin in_re[i] = int'($urandom_range(0, 4000)) - 2000;
                       in_im[i] = int'($urandom_range(0, 4000)) - 2000; end
        default: begin in_re[i] = int'($urandom_range(0, 65535)) - 32768;
                       in_im[i] = int'($urandom_range(0, 65535)) - 32768; end
      endcase
    end
  endtask

  // ---------------- drivers ----------------
  task automatic load_frame(input int n, input int bp);
    int i = 0;
    int guard = 0;
    int first_done = 0;
    logic acc;
    while (i < n && guard < 2000) begin
      s_valid = (bp != 0 && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      s_real  = DW'(in_re[i]);
      s_imag  = DW'(in_im[i]);
      check("s_ready_load", s_ready_m, 1);
      acc = s_valid && s_ready_m;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        i++;
        if (first_done == 0) begin
          first_done = 1;
          check("ovf_clear_first_input", overflow_m, 0);
        end
      end
    end
    s_valid = 1'b0;
    if (i < n) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d expected %0d", i, n);
    end
  endtask

  task automatic collect_frame(input int n, input int bp, input int exp_ovf);
    int got = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int seen_valid = 0;
    int prev_stall = 0;
    logic prev_busy = 1'b0;
    logic [W-1:0] prev_out = '0;
    logic [W-1:0] cur, e;
    while (got < n && cyc < 5000) begin
      m_ready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bp != 0) begin
        s_valid = 1'($urandom_range(0, 1));
        s_real  = DW'($urandom);
        s_imag  = DW'($urandom);
      end
      cur = {m_last_m, m_index_m, m_real_m, m_imag_m};
      if (busy_m || m_valid_m) check("s_ready_low", s_ready_m, 0);
      if (busy_m) busy_cnt++;
      if (m_valid_m && seen_valid == 0) begin
        seen_valid = 1;
        check("busy_cycles", busy_cnt, (n / 2) * $clog2(n));
        check("valid_after_busy", {prev_busy, busy_m}, 2'b10);
      end
      if (prev_stall != 0) begin
        check("stall_valid_hold", m_valid_m, 1);
        check_vec("stall_data_hold", cur, prev_out);
      end
      if (m_valid_m && m_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_bin: got idx=%0d expected no bin", m_index_m);
        end else begin
          e = exp_q.pop_front();
          check_vec("bin", cur, e);
        end
        got_re[m_index_m] = int'($signed(m_real_m));
        got_im[m_index_m] = int'($signed(m_imag_m));
        got++;
      end
      prev_stall = (m_valid_m && !m_ready) ? 1 : 0;
      prev_out   = cur;
      prev_busy  = busy_m;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    if (got < n) begin
      errors++;
      $display("FAIL unload_timeout: got %0d bins expected %0d", got, n);
    end
    exp_q.delete();
    check("m_valid_after_frame", m_valid_m, 0);
    check("overflow_frame", overflow_m, exp_ovf);
  endtask

  task automatic run_frame(input int sel_i, input int pat, input int bp);
    int n;
    sel = sel_i;
    n = (sel_i == 2) ? 16 : 8;
    for (int i = 0; i < 256; i++) begin got_re[i] = -99999; got_im[i] = -99999; end
    fill(pat, n);
    model(n, (sel_i == 1) ? 1 : 0);
    #1;
    load_frame(n, bp);
    collect_frame(n, bp, model_ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready_m, 1);
    check({tag, "_m_valid"}, m_valid_m, 0);
    check({tag, "_m_real"}, m_real_m, 0);
    check({tag, "_m_imag"}, m_imag_m, 0);
    check({tag, "_m_index"}, m_index_m, 0);
    check({tag, "_m_last"}, m_last_m, 0);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_overflow"}, overflow_m, 0);
  endtask

  initial begin
    checks = 0; errors = 0; sel = 0;
    s_valid = 1'b0; m_ready = 1'b0; s_real = '0; s_imag = '0;
    arst_n = 1'b0;

    vecs[0] = '{0, P_IMP,  3, 256,   0,   0, 0};
    vecs[1] = '{0, P_IMP,  7, 256,   0,   0, 0};
    vecs[2] = '{1, P_RAMP, 0, 1152,  256, 0, 0};
    vecs[3] = '{1, P_RAMP, 0, 1152,  256, 0, 1};
    vecs[4] = '{0, P_ALT,  4, 2048,  0,   0, 0};
    vecs[5] = '{0, P_ALT,  6, 0,     0,   0, 0};
    vecs[6] = '{2, P_ALT,  8, 4096,  0,   0, 0};
    vecs[7] = '{2, P_ALT,  3, 0,     0,   0, 1};
    vecs[8] = '{0, P_SAT,  0, 32767, 0,   1, 0};
    vecs[9] = '{0, P_IMP,  0, 256,   0,   0, 1};

    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check_reset_outputs("reset");
    end
    sel = 0;
    @(posedge clk); #3;
    arst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      run_frame(vecs[v].sel, vecs[v].pat, vecs[v].bp);
      check("vec_bin_re", got_re[vecs[v].bin], vecs[v].exp_re);
      check("vec_bin_im", got_im[vecs[v].bin], vecs[v].exp_im);
      check("vec_overflow", overflow_m, vecs[v].exp_ovf);
    end

    for (int r = 0; r < 9; r++) run_frame(r % 3, P_RND, (r >= 3) ? 1 : 0);
    run_frame(0, P_FULL, 1);
    run_frame(2, P_FULL, 0);

    // Reset in the middle of COMPUTE after a saturating butterfly has set overflow.
    sel = 0;
    fill(P_SAT, 8);
    #1;
    load_frame(8, 0);
    repeat (3) @(posedge clk);
    #2;
    check("mid_compute_busy", busy_m, 1);
    check("mid_compute_overflow", overflow_m, 1);
    arst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #3;
    arst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, P_IMP, 0);
    for (int i = 0; i < 8; i++) begin
      check("post_reset_re", got_re[i], 256);
      check("post_reset_im", got_im[i], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
